// File: rtl/rgb2yuv_csc.sv
// rgb2yuv_csc: RGB565/RGB888 to 8-bit YCbCr converter with four run-time
// coefficient sets, 4:4:4 or co-sited 4:2:2 chroma output, a grey RGB565
// preview word, and sync/blank delay lines matched to the 3-clock pipeline.
module rgb2yuv_csc #(
  parameter int IN_FMT   = 0,
  parameter int IN_W     = 24,
  parameter int DEF_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_HSYNC,
  input  logic            i_VSYNC,
  input  logic            i_BLANK,
  input  logic [IN_W-1:0] i_display_data,
  input  logic [1:0]      i_mode,
  input  logic            i_fmt422,
  output logic            H_SYNC,
  output logic            V_SYNC,
  output logic            BLANK,
  output logic [7:0]      o_Y,
  output logic [7:0]      o_U,
  output logic [7:0]      o_V,
  output logic [7:0]      o_C,
  output logic            o_cphase,
  output logic [15:0]     display_data
);

  typedef enum logic [1:0] {
    CSC_601_FULL = 2'd0,
    CSC_601_LIM  = 2'd1,
    CSC_709_FULL = 2'd2,
    CSC_709_LIM  = 2'd3
  } csc_mode_e;

  localparam csc_mode_e RST_MODE = csc_mode_e'(2'(DEF_MODE));

  logic [7:0] r8, g8, b8;
  logic       unused_in;

  generate
    if (IN_FMT == 0) begin : g_565
      assign r8 = {i_display_data[15:11], i_display_data[15:13]};
      assign g8 = {i_display_data[10:5],  i_display_data[10:9]};
      assign b8 = {i_display_data[4:0],   i_display_data[4:2]};
    end else begin : g_888
      assign r8 = i_display_data[23:16];
      assign g8 = i_display_data[15:8];
      assign b8 = i_display_data[7:0];
    end
  endgenerate

  // Upper input bits are unused when a 16-bit source sits on a wider bus.
  assign unused_in = ^i_display_data;

  csc_mode_e          mode_r;
  logic               fmt_r;
  logic [2:0]         hs_d, vs_d, bl_d;
  logic signed [8:0]  coef [9];
  logic signed [8:0]  comp [3];
  logic               lim;
  logic signed [17:0] prod [9];
  logic               yoff_s1, fmt_s1, fmt_s2;
  logic signed [19:0] sum_y, sum_u, sum_v;
  logic [7:0]         y_sat, u_sat, v_sat;
  logic               ph;
  logic [7:0]         held_v;

  function automatic logic signed [19:0] sx(input logic signed [17:0] p);
    return {{2{p[17]}}, p};
  endfunction

  // Arithmetic >>8 of the rounded sum, clamped to 0..255.
  function automatic logic [7:0] sat8(input logic signed [19:0] s);
    if (s[19])
      return 8'h00;
    else if (s[18:16] != 3'b000)
      return 8'hFF;
    else
      return s[15:8];
  endfunction

  // Coefficient set for the active mode; rows are Y, U, V over R, G, B.
  always_comb begin
    case (mode_r)
      CSC_601_FULL: coef = '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128,
                             9'sd128, -9'sd107, -9'sd21};
      CSC_601_LIM:  coef = '{9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112,
                             9'sd112, -9'sd94, -9'sd18};
      CSC_709_FULL: coef = '{9'sd54, 9'sd183, 9'sd19, -9'sd29, -9'sd99, 9'sd128,
                             9'sd128, -9'sd116, -9'sd12};
      default:      coef = '{9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd86, 9'sd112,
                             9'sd112, -9'sd102, -9'sd10};
    endcase
    lim     = (mode_r == CSC_601_LIM) || (mode_r == CSC_709_LIM);
    comp[0] = {1'b0, r8};
    comp[1] = {1'b0, g8};
    comp[2] = {1'b0, b8};
  end

  // Config is taken only at frame start, when the registered VSYNC rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= RST_MODE;
      fmt_r  <= 1'b0;
    end else if (i_VSYNC && !vs_d[0]) begin
      mode_r <= csc_mode_e'(i_mode);
      fmt_r  <= i_fmt422;
    end
  end

  // Sync/blank delay lines matching the data latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d <= '0;
      vs_d <= '0;
      bl_d <= '0;
    end else begin
      hs_d <= {hs_d[1:0], i_HSYNC};
      vs_d <= {vs_d[1:0], i_VSYNC};
      bl_d <= {bl_d[1:0], i_BLANK};
    end
  end

  assign H_SYNC = hs_d[2];
  assign V_SYNC = vs_d[2];
  assign BLANK  = bl_d[2];

  // Stage 1: nine signed products; Y offset and format travel with the pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 9; k++) prod[k] <= '0;
      yoff_s1 <= 1'b0;
      fmt_s1  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 9; k++) prod[k] <= coef[k] * comp[k % 3];
      yoff_s1 <= lim;
      fmt_s1  <= fmt_r;
    end
  end

  // Stage 2: sums with offset and rounding constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_y  <= '0;
      sum_u  <= '0;
      sum_v  <= '0;
      fmt_s2 <= 1'b0;
    end else begin
      sum_y  <= sx(prod[0]) + sx(prod[1]) + sx(prod[2]) +
                (yoff_s1 ? 20'sd4224 : 20'sd128);
      sum_u  <= sx(prod[3]) + sx(prod[4]) + sx(prod[5]) + 20'sd32896;
      sum_v  <= sx(prod[6]) + sx(prod[7]) + sx(prod[8]) + 20'sd32896;
      fmt_s2 <= fmt_s1;
    end
  end

  // Stage 3 shift/saturate.
  always_comb begin
    y_sat = sat8(sum_y);
    u_sat = sat8(sum_u);
    v_sat = sat8(sum_v);
  end

  // Output registers; ph is the phase the next active pixel will carry, so
  // o_cphase restarts at 0 on the first pixel after any blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_Y          <= '0;
      o_U          <= '0;
      o_V          <= '0;
      o_C          <= '0;
      o_cphase     <= 1'b0;
      display_data <= '0;
      ph           <= 1'b0;
      held_v       <= '0;
    end else begin
      o_Y          <= y_sat;
      o_U          <= u_sat;
      o_V          <= v_sat;
      display_data <= {y_sat[7:3], y_sat[7:2], y_sat[7:3]};
      if (!fmt_s2 || bl_d[1]) begin
        o_C      <= u_sat;
        o_cphase <= 1'b0;
        ph       <= 1'b0;
      end else if (!ph) begin
        o_C      <= u_sat;
        held_v   <= v_sat;
        o_cphase <= 1'b0;
        ph       <= 1'b1;
      end else begin
        o_C      <= held_v;
        o_cphase <= 1'b1;
        ph       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb2yuv_csc.sv
// Bench for rgb2yuv_csc (RGB565 input, default mode 0): directed spec cases
// plus randomized pixels against an arithmetic reference model.
module tb_rgb2yuv_csc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, vs = 1'b0, bl = 1'b1;
  logic [15:0] din = '0;
  logic [1:0]  mode = '0;
  logic        f422 = 1'b0;
  logic        H_SYNC, V_SYNC, BLANK, o_cphase;
  logic [7:0]  o_Y, o_U, o_V, o_C;
  logic [15:0] display_data;

  int total = 0;
  int bad = 0;

  typedef struct {
    int   y, u, v, g, c;
    logic h, vv, b, cph, chk_c;
  } exp_t;

  rgb2yuv_csc #(.IN_FMT(0), .IN_W(16), .DEF_MODE(0)) dut (
    .clk(clk), .rst(rst), .i_HSYNC(hs), .i_VSYNC(vs), .i_BLANK(bl),
    .i_display_data(din), .i_mode(mode), .i_fmt422(f422),
    .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .BLANK(BLANK),
    .o_Y(o_Y), .o_U(o_U), .o_V(o_V), .o_C(o_C), .o_cphase(o_cphase),
    .display_data(display_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int clamp8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  // Reference: expand 565 to 8 bits, Q8 dot product, round, floor-shift, clamp.
  function automatic void model(input logic [15:0] px, input int m,
                                output int y, output int u, output int v, output int g);
    int r, gg, b, off;
    int cy[3], cu[3], cv[3];
    r  = int'(px[15:11]); r  = r * 8 + r / 4;
    gg = int'(px[10:5]);  gg = gg * 4 + gg / 16;
    b  = int'(px[4:0]);   b  = b * 8 + b / 4;
    case (m)
      0: begin cy = '{77, 150, 29}; cu = '{-43, -85, 128}; cv = '{128, -107, -21}; off = 0;  end
      1: begin cy = '{66, 129, 25}; cu = '{-38, -74, 112}; cv = '{112, -94, -18};  off = 16; end
      2: begin cy = '{54, 183, 19}; cu = '{-29, -99, 128}; cv = '{128, -116, -12}; off = 0;  end
      default: begin cy = '{47, 157, 16}; cu = '{-26, -86, 112}; cv = '{112, -102, -10}; off = 16; end
    endcase
    y = clamp8((cy[0] * r + cy[1] * gg + cy[2] * b + off * 256 + 128) >>> 8);
    u = clamp8((cu[0] * r + cu[1] * gg + cu[2] * b + 128 * 256 + 128) >>> 8);
    v = clamp8((cv[0] * r + cv[1] * gg + cv[2] * b + 128 * 256 + 128) >>> 8);
    g = ((y / 8) << 11) | ((y / 4) << 5) | (y / 8);
  endfunction

  task automatic set_cfg(input int m, input logic f);
    mode = 2'(m); f422 = f; bl = 1'b1; vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({o_Y, o_U, o_V, o_C, o_cphase, display_data, H_SYNC, V_SYNC, BLANK} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: Y=%0d U=%0d V=%0d C=%0d cph=%0b dd=%h sync=%b%b%b want all 0",
               o_Y, o_U, o_V, o_C, o_cphase, display_data, H_SYNC, V_SYNC, BLANK);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_red_565();
    bl = 1'b0; din = 16'hF800;
    tick();
    din = 16'h0000;
    repeat (2) tick();
    total++;
    if (o_Y !== 8'd77) begin bad++; $display("FAIL red_Y: got %0d want 77", o_Y); end
    total++;
    if (o_U !== 8'd85) begin bad++; $display("FAIL red_U: got %0d want 85", o_U); end
    total++;
    if (o_V !== 8'd255) begin bad++; $display("FAIL red_V_sat: got %0d want 255", o_V); end
    total++;
    if (display_data !== 16'h4A69) begin bad++; $display("FAIL red_grey: got %h want 4a69", display_data); end
    total++;
    if (o_C !== 8'd85 || o_cphase !== 1'b0) begin
      bad++; $display("FAIL red_444_chroma: C=%0d cph=%0b want C=85 cph=0", o_C, o_cphase);
    end
  endtask

  task automatic test_mode1_limited();
    set_cfg(1, 1'b0);
    bl = 1'b0; din = 16'hFFFF;
    tick();
    din = 16'h0000;
    repeat (2) tick();
    total++;
    if ({o_Y, o_U, o_V} !== {8'd235, 8'd128, 8'd128}) begin
      bad++; $display("FAIL lim_white: got Y=%0d U=%0d V=%0d want 235/128/128", o_Y, o_U, o_V);
    end
    tick();
    total++;
    if ({o_Y, o_U, o_V} !== {8'd16, 8'd128, 8'd128}) begin
      bad++; $display("FAIL lim_black: got Y=%0d U=%0d V=%0d want 16/128/128", o_Y, o_U, o_V);
    end
  endtask

  task automatic test_mode_latch();
    set_cfg(0, 1'b0);
    mode = 2'd2;
    bl = 1'b0; din = 16'hF800;
    repeat (3) tick();
    total++;
    if (o_Y !== 8'd77) begin bad++; $display("FAIL midframe_ignored: got Y=%0d want 77", o_Y); end
    vs = 1'b1;
    tick();
    vs = 1'b0;
    repeat (4) tick();
    total++;
    if (o_Y !== 8'd54) begin bad++; $display("FAIL latched_mode2_red: got Y=%0d want 54", o_Y); end
    din = 16'hFFFF;
    repeat (3) tick();
    total++;
    if (o_Y !== 8'd255) begin bad++; $display("FAIL latched_mode2_white: got Y=%0d want 255", o_Y); end
  endtask

  task automatic test_random_444();
    exp_t q[$];
    exp_t e;
    logic [15:0] px;
    int y, u, v, g;
    for (int m = 0; m < 4; m++) begin
      set_cfg(m, 1'b0);
      for (int i = 0; i < 27; i++) begin
        if (i >= 3) begin
          e = q.pop_front();
          total++;
          if ({o_Y, o_U, o_V} !== {8'(e.y), 8'(e.u), 8'(e.v)}) begin
            bad++;
            $display("FAIL rand_yuv m%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                     m, o_Y, o_U, o_V, e.y, e.u, e.v);
          end
          total++;
          if (display_data !== 16'(e.g) || o_C !== 8'(e.u) || o_cphase !== 1'b0) begin
            bad++;
            $display("FAIL rand_grey_c m%0d: dd=%h C=%0d cph=%0b want dd=%h C=%0d cph=0",
                     m, display_data, o_C, o_cphase, 16'(e.g), e.u);
          end
          total++;
          if ({H_SYNC, V_SYNC, BLANK} !== {e.h, e.vv, e.b}) begin
            bad++;
            $display("FAIL rand_sync m%0d: got %b%b%b want %b%b%b",
                     m, H_SYNC, V_SYNC, BLANK, e.h, e.vv, e.b);
          end
        end
        if (i < 24) begin
          px = 16'($urandom);
          din = px; hs = 1'($urandom); vs = 1'($urandom); bl = 1'($urandom);
          model(px, m, y, u, v, g);
          e.y = y; e.u = u; e.v = v; e.g = g; e.h = hs; e.vv = vs; e.b = bl;
          q.push_back(e);
        end
        tick();
      end
      hs = 1'b0; vs = 1'b0;
    end
  endtask

  task automatic test_422();
    logic [15:0] pxq[$];
    logic        blq[$];
    exp_t q[$];
    exp_t e;
    int y, u, v, g, k, lastv, n, len;
    set_cfg(0, 1'b1);
    pxq = '{16'h0000, 16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'h0000, 16'h0000, 16'h0000};
    blq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int l = 0; l < 2; l++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin pxq.push_back(16'($urandom)); blq.push_back(1'b0); end
      for (int i = 0; i < 3; i++) begin pxq.push_back(16'($urandom)); blq.push_back(1'b1); end
    end
    n = pxq.size();
    k = 0; lastv = 0;
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 3) begin
        e = q.pop_front();
        total++;
        if (o_cphase !== e.cph) begin
          bad++; $display("FAIL c422_phase cyc%0d: got %0b want %0b", i, o_cphase, e.cph);
        end
        if (e.chk_c) begin
          total++;
          if (o_C !== 8'(e.c) || o_U !== 8'(e.u) || o_V !== 8'(e.v)) begin
            bad++;
            $display("FAIL c422_chroma cyc%0d: C=%0d U=%0d V=%0d want C=%0d U=%0d V=%0d",
                     i, o_C, o_U, o_V, e.c, e.u, e.v);
          end
        end
      end
      if (i < n) begin
        din = pxq[i]; bl = blq[i];
        model(pxq[i], 0, y, u, v, g);
        e.u = u; e.v = v; e.c = 0;
        if (blq[i]) begin
          k = 0; e.cph = 1'b0; e.chk_c = 1'b0;
        end else begin
          e.cph = 1'(k % 2); e.chk_c = 1'b1;
          if (k % 2 == 0) begin e.c = u; lastv = v; end
          else e.c = lastv;
          k++;
        end
        q.push_back(e);
      end
      tick();
    end
  endtask

  task automatic test_sync_pulse();
    logic [11:0] hseq, vseq, bseq;
    set_cfg(0, 1'b0);
    hseq = 12'b000000000010;
    vseq = 12'b000000001000;
    bseq = 12'b000000100000;
    bl = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i >= 3) begin
        total++;
        if ({H_SYNC, V_SYNC, BLANK} !== {hseq[i-3], vseq[i-3], bseq[i-3]}) begin
          bad++;
          $display("FAIL sync_delay3 cyc%0d: got %b%b%b want %b%b%b", i,
                   H_SYNC, V_SYNC, BLANK, hseq[i-3], vseq[i-3], bseq[i-3]);
        end
      end
      hs = hseq[i]; vs = vseq[i]; bl = bseq[i];
      tick();
    end
  endtask

  task automatic test_async_reset();
    set_cfg(2, 1'b1);
    bl = 1'b0; din = 16'hFFFF;
    repeat (4) tick();
    total++;
    if (display_data !== 16'hFFFF) begin
      bad++; $display("FAIL prereset_white: got dd=%h want ffff", display_data);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_Y, o_U, o_V, o_C, o_cphase, display_data, H_SYNC, V_SYNC, BLANK} !== '0) begin
      bad++;
      $display("FAIL async_reset: Y=%0d U=%0d V=%0d C=%0d cph=%0b dd=%h want all 0",
               o_Y, o_U, o_V, o_C, o_cphase, display_data);
    end
    tick();
    rst = 1'b0;
    mode = 2'd2; f422 = 1'b1; bl = 1'b0; din = 16'hF800;
    repeat (3) tick();
    total++;
    if (o_Y !== 8'd77 || o_C !== 8'd85 || o_cphase !== 1'b0) begin
      bad++; $display("FAIL postreset_px0: Y=%0d C=%0d cph=%0b want 77/85/0", o_Y, o_C, o_cphase);
    end
    tick();
    total++;
    if (o_C !== 8'd85 || o_cphase !== 1'b0) begin
      bad++; $display("FAIL postreset_444: C=%0d cph=%0b want 85/0", o_C, o_cphase);
    end
  endtask

  initial begin
    test_reset();
    test_red_565();
    test_mode1_limited();
    test_mode_latch();
    test_random_444();
    test_422();
    test_sync_pulse();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
